// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - buffered UART endpoint: RX/TX FIFOs, TX launch FSM, occupancy and sticky status
//
// uart_fifo ports:
//   clk, reset_n                  system clock, synchronous active-low reset (also resets both cores)
//   uart_rxd, uart_txd            serial pins
//   uart_rx_en                    receive enable forwarded to the RX core
//   tx_data/tx_valid/tx_ready     byte stream into the TX FIFO
//   rx_data/rx_valid/rx_ready     first-word fall-through byte stream out of the RX FIFO
//   tx_count, rx_count            FIFO occupancies
//   rx_overrun, rx_break          sticky status, cleared by the status_clr pulse
//   tx_idle                       TX FIFO empty, launch FSM idle and TX core not busy
//
// Helper modules in this file: uart_fifo_buf (FWFT FIFO), uart_tx, uart_rx (serial cores).

module uart_fifo_buf #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage is deliberately not reset; head is only meaningful while not empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Callers qualify push/pop, so count never leaves 0..DEPTH. Pointers wrap
   // naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
endmodule

module uart_tx #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   output logic                    uart_txd,
   output logic                    uart_tx_busy,
   input  logic                    uart_tx_en,
   input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int CW = $clog2(CYCLES_PER_BIT + 1);
   localparam int BW = $clog2(PAYLOAD_BITS + 1);

   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [CW-1:0]           cycle_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic                    bit_done;

   assign bit_done = (cycle_cnt == CW'(CYCLES_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (!resetn) state <= T_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         T_IDLE:  if (uart_tx_en) state_nxt = T_START;
         T_START: if (bit_done) state_nxt = T_DATA;
         T_DATA:  if (bit_done && bit_cnt == BW'(PAYLOAD_BITS - 1)) state_nxt = T_STOP;
         T_STOP:  if (bit_done) state_nxt = T_IDLE;
         default: state_nxt = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cycle_cnt <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
      end else begin
         if (state == T_IDLE || bit_done) cycle_cnt <= '0;
         else                             cycle_cnt <= cycle_cnt + CW'(1);
         if (state == T_IDLE) begin
            bit_cnt <= '0;
            if (uart_tx_en) shreg <= uart_tx_data;
         end else if (state == T_DATA && bit_done) begin
            bit_cnt <= bit_cnt + BW'(1);
            shreg   <= shreg >> 1;
         end
      end
   end

   // Line level is decoded from registered state only, LSB first.
   always_comb begin
      uart_tx_busy = (state != T_IDLE);
      case (state)
         T_START: uart_txd = 1'b0;
         T_DATA:  uart_txd = shreg[0];
         default: uart_txd = 1'b1;
      endcase
   end
endmodule

module uart_rx #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_rxd,
   input  logic                    uart_rx_en,
   output logic                    uart_rx_break,
   output logic                    uart_rx_valid,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data
);
   localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int HALF_BIT = CYCLES_PER_BIT / 2;
   localparam int CW = $clog2(CYCLES_PER_BIT + 1);
   localparam int BW = $clog2(PAYLOAD_BITS + 1);

   // R_HOLD waits for the line to return high after a bad stop bit so a
   // long BREAK is reported once rather than once per frame time.
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_HOLD} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    rxd_meta;
   logic                    rxd_sync;
   logic [CW-1:0]           cycle_cnt;
   logic [BW-1:0]           bit_cnt;
   logic [PAYLOAD_BITS-1:0] shreg;
   logic                    half_done;
   logic                    bit_done;
   logic                    stop_sample;

   assign half_done   = (cycle_cnt == CW'(HALF_BIT - 1));
   assign bit_done    = (cycle_cnt == CW'(CYCLES_PER_BIT - 1));
   assign stop_sample = (state == R_STOP) && bit_done;

   always_ff @(posedge clk) begin
      if (!resetn) state <= R_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         R_IDLE:  if (uart_rx_en && !rxd_sync) state_nxt = R_START;
         R_START: if (half_done) state_nxt = rxd_sync ? R_IDLE : R_DATA;
         R_DATA:  if (bit_done && bit_cnt == BW'(PAYLOAD_BITS - 1)) state_nxt = R_STOP;
         R_STOP:  if (bit_done) state_nxt = rxd_sync ? R_IDLE : R_HOLD;
         R_HOLD:  if (rxd_sync) state_nxt = R_IDLE;
         default: state_nxt = R_IDLE;
      endcase
   end

   // After the half-bit start check, every later sample lands mid-bit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rxd_meta      <= 1'b1;
         rxd_sync      <= 1'b1;
         cycle_cnt     <= '0;
         bit_cnt       <= '0;
         shreg         <= '0;
         uart_rx_valid <= 1'b0;
         uart_rx_break <= 1'b0;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
         if (state_nxt != state || bit_done || state == R_IDLE || state == R_HOLD)
            cycle_cnt <= '0;
         else
            cycle_cnt <= cycle_cnt + CW'(1);
         if (state == R_IDLE) begin
            bit_cnt <= '0;
         end else if (state == R_DATA && bit_done) begin
            bit_cnt <= bit_cnt + BW'(1);
            shreg   <= {rxd_sync, shreg[PAYLOAD_BITS-1:1]};
         end
         uart_rx_valid <= stop_sample && rxd_sync;
         uart_rx_break <= stop_sample && !rxd_sync && (shreg == '0);
      end
   end

   assign uart_rx_data = shreg;
endmodule

module uart_fifo #(
   parameter int CLK_HZ       = 50000000,
   parameter int BIT_RATE     = 9600,
   parameter int PAYLOAD_BITS = 8,
   parameter int TX_DEPTH     = 16,
   parameter int RX_DEPTH     = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       uart_rxd,
   output logic                       uart_txd,
   input  logic                       uart_rx_en,
   input  logic [PAYLOAD_BITS-1:0]    tx_data,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic [PAYLOAD_BITS-1:0]    rx_data,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic [$clog2(TX_DEPTH):0]  tx_count,
   output logic [$clog2(RX_DEPTH):0]  rx_count,
   output logic                       rx_overrun,
   output logic                       rx_break,
   input  logic                       status_clr,
   output logic                       tx_idle
);
   logic                    uart_rx_valid;
   logic                    uart_rx_break;
   logic [PAYLOAD_BITS-1:0] uart_rx_data;
   logic                    uart_tx_busy;
   logic                    uart_tx_en;
   logic [PAYLOAD_BITS-1:0] uart_tx_data;

   uart_rx #(
      .CLK_HZ       (CLK_HZ),
      .BIT_RATE     (BIT_RATE),
      .PAYLOAD_BITS (PAYLOAD_BITS)
   ) u_rx (
      .clk           (clk),
      .resetn        (reset_n),
      .uart_rxd      (uart_rxd),
      .uart_rx_en    (uart_rx_en),
      .uart_rx_break (uart_rx_break),
      .uart_rx_valid (uart_rx_valid),
      .uart_rx_data  (uart_rx_data)
   );

   uart_tx #(
      .CLK_HZ       (CLK_HZ),
      .BIT_RATE     (BIT_RATE),
      .PAYLOAD_BITS (PAYLOAD_BITS)
   ) u_tx (
      .clk          (clk),
      .resetn       (reset_n),
      .uart_txd     (uart_txd),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data)
   );

   // ---------------- RX path ----------------
   logic rx_full;
   logic rx_empty;
   logic rx_pop;
   logic rx_push;
   logic rx_drop;

   // A full FIFO still takes the byte when the consumer frees a slot in the same cycle.
   assign rx_pop   = rx_valid && rx_ready;
   assign rx_push  = uart_rx_valid && (!rx_full || rx_pop);
   assign rx_drop  = uart_rx_valid && rx_full && !rx_pop;
   assign rx_valid = !rx_empty;

   uart_fifo_buf #(
      .DEPTH (RX_DEPTH),
      .WIDTH (PAYLOAD_BITS)
   ) u_rx_fifo (
      .clk       (clk),
      .resetn    (reset_n),
      .push      (rx_push),
      .push_data (uart_rx_data),
      .pop       (rx_pop),
      .head      (rx_data),
      .count     (rx_count),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Set beats clear so an event coincident with status_clr is not lost.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_overrun <= 1'b0;
         rx_break   <= 1'b0;
      end else begin
         if (rx_drop)         rx_overrun <= 1'b1;
         else if (status_clr) rx_overrun <= 1'b0;
         if (uart_rx_break)   rx_break <= 1'b1;
         else if (status_clr) rx_break <= 1'b0;
      end
   end

   // ---------------- TX path ----------------
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_GUARD, S_WAIT} tx_state_t;

   tx_state_t               tx_state;
   tx_state_t               tx_state_nxt;
   logic                    tx_full;
   logic                    tx_empty;
   logic                    tx_push;
   logic                    tx_pop;
   logic [PAYLOAD_BITS-1:0] tx_head;
   logic [PAYLOAD_BITS-1:0] tx_hold;

   assign tx_ready     = !tx_full;
   assign tx_push      = tx_valid && tx_ready;
   assign uart_tx_data = tx_hold;

   uart_fifo_buf #(
      .DEPTH (TX_DEPTH),
      .WIDTH (PAYLOAD_BITS)
   ) u_tx_fifo (
      .clk       (clk),
      .resetn    (reset_n),
      .push      (tx_push),
      .push_data (tx_data),
      .pop       (tx_pop),
      .head      (tx_head),
      .count     (tx_count),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) tx_state <= S_IDLE;
      else          tx_state <= tx_state_nxt;
   end

   // GUARD covers the cycle before the core reports busy; WAIT then tracks busy.
   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         S_IDLE:   if (!tx_empty && !uart_tx_busy) tx_state_nxt = S_LAUNCH;
         S_LAUNCH: tx_state_nxt = S_GUARD;
         S_GUARD:  tx_state_nxt = S_WAIT;
         S_WAIT:   if (!uart_tx_busy) tx_state_nxt = S_IDLE;
         default:  tx_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      tx_pop     = (tx_state == S_IDLE) && !tx_empty && !uart_tx_busy;
      uart_tx_en = (tx_state == S_LAUNCH);
      tx_idle    = tx_empty && (tx_state == S_IDLE) && !uart_tx_busy;
   end

   // tx_hold only moves on a pop, keeping the core's data input stable for the frame.
   always_ff @(posedge clk) begin
      if (!reset_n)    tx_hold <= '0;
      else if (tx_pop) tx_hold <= tx_head;
   end
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - directed self-checking bench for uart_fifo
//
// Drives and samples on the falling clock edge; a serial monitor decodes uart_txd
// into mon_q. Design parameters: 10 clocks per bit, both FIFOs 4 deep.

module tb_uart_fifo;
   localparam int CLK_HZ   = 1000000;
   localparam int BIT_RATE = 100000;
   localparam int DEPTH    = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       uart_rxd;
   logic       uart_txd;
   logic       uart_rx_en;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] tx_count;
   logic [2:0] rx_count;
   logic       rx_overrun;
   logic       rx_break;
   logic       status_clr;
   logic       tx_idle;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   logic [7:0] mon_q[$];

   uart_fifo #(
      .CLK_HZ       (CLK_HZ),
      .BIT_RATE     (BIT_RATE),
      .PAYLOAD_BITS (8),
      .TX_DEPTH     (DEPTH),
      .RX_DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .uart_rxd   (uart_rxd),
      .uart_txd   (uart_txd),
      .uart_rx_en (uart_rx_en),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_count   (tx_count),
      .rx_count   (rx_count),
      .rx_overrun (rx_overrun),
      .rx_break   (rx_break),
      .status_clr (status_clr),
      .tx_idle    (tx_idle)
   );

   always #5 clk = ~clk;

   // Serial monitor: detect start bit, sample each bit in its middle.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (uart_txd === 1'b0) begin
            repeat (15) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               b[i] = uart_txd;
               if (i < 7) repeat (10) @(negedge clk);
            end
            repeat (10) @(negedge clk);
            mon_q.push_back(b);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] got(input int k);
      if (k < mon_q.size()) return mon_q[k];
      return 8'hxx;
   endfunction

   task automatic wait_frames(input int n, input int budget, input string tag);
      int c = 0;
      while (mon_q.size() < n && c < budget) begin
         tick(1);
         c++;
      end
      check(tag, mon_q.size(), n);
   endtask

   task automatic wait_tx_idle(input int budget, input string tag);
      int c = 0;
      while (tx_idle !== 1'b1 && c < budget) begin
         tick(1);
         c++;
      end
      check(tag, tx_idle, 1'b1);
   endtask

   task automatic send_rx(input logic [7:0] b);
      uart_rxd = 1'b0;
      tick(10);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         tick(10);
      end
      uart_rxd = 1'b1;
      tick(10);
   endtask

   task automatic pop_rx(input logic [7:0] exp, input string tag);
      check({tag, " valid"}, rx_valid, 1'b1);
      check({tag, " data"}, rx_data, exp);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   initial begin
      logic [7:0] burst [4];
      logic [7:0] full5 [5];
      int         maxc;
      int         cyc;
      int         idx;
      int         w;
      logic       accept;
      logic       saw_full;
      logic       bad_ready;
      logic       low_seen;
      logic       timed_out;

      burst = '{8'h55, 8'hA3, 8'h00, 8'hFF};
      full5 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

      reset_n    = 1'b0;
      uart_rxd   = 1'b1;
      uart_rx_en = 1'b1;
      tx_data    = '0;
      tx_valid   = 1'b0;
      rx_ready   = 1'b0;
      status_clr = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);

      // ---- reset state ----
      check("reset tx_ready", tx_ready, 1'b1);
      check("reset rx_valid", rx_valid, 1'b0);
      check("reset tx_count", tx_count, 3'd0);
      check("reset rx_count", rx_count, 3'd0);
      check("reset flags", {rx_overrun, rx_break}, 2'b00);
      check("reset tx_idle", tx_idle, 1'b1);
      check("reset uart_txd", uart_txd, 1'b1);

      // ---- TX burst ----
      maxc = 0;
      for (int i = 0; i < 4; i++) begin
         tx_data  = burst[i];
         tx_valid = 1'b1;
         check($sformatf("burst tx_ready %0d", i), tx_ready, 1'b1);
         tick(1);
         if (int'(tx_count) > maxc) maxc = int'(tx_count);
         if (i == 0) check("burst tx_idle falls", tx_idle, 1'b0);
      end
      tx_valid = 1'b0;
      check("burst max count 3..4", (maxc == 3 || maxc == 4), 1'b1);
      wait_frames(4, 800, "burst frames");
      for (int i = 0; i < 4; i++)
         check($sformatf("burst byte %0d", i), got(i), burst[i]);
      wait_tx_idle(30, "burst tx_idle");
      check("burst tx_count end", tx_count, 3'd0);

      // ---- TX full ----
      mon_q.delete();
      push_tx(8'h01);
      tick(10);
      idx = 0;
      cyc = 0;
      saw_full = 1'b0;
      bad_ready = 1'b0;
      while (idx < 5 && cyc < 2000) begin
         tx_data  = full5[idx];
         tx_valid = 1'b1;
         accept   = tx_ready;
         tick(1);
         cyc++;
         if (accept) idx++;
         if (tx_count == 3'd4) begin
            saw_full = 1'b1;
            if (tx_ready !== 1'b0) bad_ready = 1'b1;
         end
      end
      tx_valid = 1'b0;
      check("full pushes done", idx, 5);
      check("full reached 4", saw_full, 1'b1);
      check("full tx_ready low", bad_ready, 1'b0);
      check("full 5th waited", cyc > 20, 1'b1);
      wait_frames(6, 1200, "full frames");
      check("full byte 0", got(0), 8'h01);
      for (int i = 0; i < 5; i++)
         check($sformatf("full byte %0d", i + 1), got(i + 1), full5[i]);
      wait_tx_idle(30, "full tx_idle");

      // ---- RX overrun ----
      for (int i = 0; i < 4; i++) begin
         send_rx(8'h11 + 8'(i));
         tick(5);
      end
      check("ovr count before", rx_count, 3'd4);
      check("ovr flag before", rx_overrun, 1'b0);
      send_rx(8'h15);
      tick(5);
      check("ovr count", rx_count, 3'd4);
      check("ovr flag", rx_overrun, 1'b1);
      for (int i = 0; i < 4; i++)
         pop_rx(8'h11 + 8'(i), $sformatf("ovr drain %0d", i));
      check("ovr empty", rx_valid, 1'b0);
      check("ovr flag kept", rx_overrun, 1'b1);
      status_clr = 1'b1;
      tick(1);
      status_clr = 1'b0;
      check("ovr cleared", rx_overrun, 1'b0);

      // ---- RX full with simultaneous pop ----
      for (int i = 0; i < 4; i++) begin
         send_rx(8'h21 + 8'(i));
         tick(5);
      end
      check("fullpop count before", rx_count, 3'd4);
      timed_out = 1'b0;
      fork
         send_rx(8'h25);
         begin
            w = 0;
            while (dut.uart_rx_valid !== 1'b1 && w < 300) begin
               tick(1);
               w++;
            end
            if (w >= 300) timed_out = 1'b1;
            check("fullpop head", rx_data, 8'h21);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
         end
      join
      tick(5);
      check("fullpop pulse seen", timed_out, 1'b0);
      check("fullpop count", rx_count, 3'd4);
      check("fullpop no overrun", rx_overrun, 1'b0);
      for (int i = 0; i < 4; i++)
         pop_rx(8'h22 + 8'(i), $sformatf("fullpop drain %0d", i));

      // ---- Break ----
      send_rx(8'h31);
      tick(5);
      uart_rxd = 1'b0;
      tick(200);
      uart_rxd = 1'b1;
      tick(20);
      check("break flag", rx_break, 1'b1);
      check("break count", rx_count, 3'd1);
      status_clr = 1'b1;
      tick(1);
      status_clr = 1'b0;
      check("break cleared", rx_break, 1'b0);
      timed_out = 1'b0;
      fork
         begin
            uart_rxd = 1'b0;
            tick(200);
            uart_rxd = 1'b1;
            tick(20);
         end
         begin
            w = 0;
            while (dut.uart_rx_break !== 1'b1 && w < 300) begin
               tick(1);
               w++;
            end
            if (w >= 300) timed_out = 1'b1;
            status_clr = 1'b1;
            tick(1);
            status_clr = 1'b0;
         end
      join
      check("break2 pulse seen", timed_out, 1'b0);
      check("break set beats clear", rx_break, 1'b1);
      check("break2 count", rx_count, 3'd1);

      // ---- Reset mid-frame ----
      push_tx(8'h5A);
      push_tx(8'h3C);
      push_tx(8'h99);
      tick(33);
      check("midrst queued", tx_count, 3'd2);
      check("midrst in frame", tx_idle, 1'b0);
      check("midrst rx_valid before", rx_valid, 1'b1);
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      check("midrst tx_count", tx_count, 3'd0);
      check("midrst rx_count", rx_count, 3'd0);
      check("midrst tx_ready", tx_ready, 1'b1);
      check("midrst rx_valid", rx_valid, 1'b0);
      check("midrst flags", {rx_overrun, rx_break}, 2'b00);
      check("midrst uart_txd", uart_txd, 1'b1);
      low_seen = 1'b0;
      for (int i = 0; i < 400; i++) begin
         tick(1);
         if (uart_txd !== 1'b1) low_seen = 1'b1;
      end
      check("midrst no frames", low_seen, 1'b0);
      check("midrst tx_idle", tx_idle, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
